// File: rtl/alu_pkg.sv
// Shared ALU datapath types: operand widths, lookahead block size and the
// per-stage pipeline record used by the subtractor.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NBLK  = 4;

    typedef logic [BLK-1:0]   blk_t;
    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        logic  valid;
        word_t a;
        word_t b;
        word_t d;
        logic  borrow;
    } stage_t;

endpackage

// File: rtl/pipelined_subtractor_sub_block.sv
// Combinational BLK-bit borrow-lookahead subtractor: d = a - b - bin, with
// group generate/propagate exported for hierarchical lookahead.
module sub_block
    import alu_pkg::*;
(
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           bin,
    output logic [BLK-1:0] d,
    output logic           bout,
    output logic           gb,
    output logic           pb
);

    logic [BLK-1:0] g_bit;
    logic [BLK-1:0] p_bit;
    logic [BLK-1:0] bw;
    logic           grp_g;
    logic           term;

    // Every internal borrow is a flat sum-of-products of the bit
    // generates/propagates, so no borrow waits on its neighbour.
    always_comb begin
        g_bit = ~a & b;
        p_bit = ~(a ^ b);
        bw    = '0;
        grp_g = 1'b0;
        term  = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            term = bin;
            for (int j = 0; j < i; j++) term = term & p_bit[j];
            bw[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g_bit[j];
                for (int m = j + 1; m < i; m++) term = term & p_bit[m];
                bw[i] = bw[i] | term;
            end
        end
        for (int j = 0; j < BLK; j++) begin
            term = g_bit[j];
            for (int m = j + 1; m < BLK; m++) term = term & p_bit[m];
            grp_g = grp_g | term;
        end
        gb   = grp_g;
        pb   = &p_bit;
        bout = grp_g | (&p_bit & bin);
        d    = a ^ b ^ bw;
    end

endmodule

// File: rtl/pipelined_subtractor.sv
// 16-bit unsigned a - b as a NBLK-stage pipeline, one borrow-lookahead block
// per stage, with a valid/ready handshake that stalls the whole pipe at once.
module pipelined_subtractor
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    stage_t           st      [NBLK];
    stage_t           nxt     [NBLK];
    logic [WIDTH-1:0] src_a   [NBLK];
    logic [WIDTH-1:0] src_b   [NBLK];
    logic [WIDTH-1:0] src_d   [NBLK];
    logic             src_v   [NBLK];
    logic             src_bin [NBLK];
    blk_t             blk_d   [NBLK];
    logic [NBLK-1:0]  blk_bout;
    logic [NBLK-1:0]  blk_gg;
    logic [NBLK-1:0]  blk_gp;
    logic             zero_q;
    logic             adv;
    logic             unused_bits;

    assign adv      = !st[NBLK-1].valid || out_ready;
    assign in_ready = adv;

    // Stage k works on whatever sits in front of it: the ports for stage 0,
    // otherwise the register of stage k-1.
    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            if (k == 0) begin
                src_v[k]   = in_valid;
                src_a[k]   = a;
                src_b[k]   = b;
                src_d[k]   = '0;
                src_bin[k] = 1'b0;
            end else begin
                src_v[k]   = st[k-1].valid;
                src_a[k]   = st[k-1].a;
                src_b[k]   = st[k-1].b;
                src_d[k]   = st[k-1].d;
                src_bin[k] = st[k-1].borrow;
            end
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        sub_block u_sub (
            .a    (src_a[k][k*BLK +: BLK]),
            .b    (src_b[k][k*BLK +: BLK]),
            .bin  (src_bin[k]),
            .d    (blk_d[k]),
            .bout (blk_bout[k]),
            .gb   (blk_gg[k]),
            .pb   (blk_gp[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            nxt[k].valid              = src_v[k];
            nxt[k].a                  = src_a[k];
            nxt[k].b                  = src_b[k];
            nxt[k].d                  = src_d[k];
            nxt[k].d[k*BLK +: BLK]    = blk_d[k];
            nxt[k].borrow             = blk_bout[k];
        end
    end

    // Zero is decided from the final stage's next value so the flag is
    // registered alongside diff instead of trailing it by a compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) st[k] <= '0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NBLK; k++) st[k] <= nxt[k];
            zero_q <= (nxt[NBLK-1].d == '0);
        end
    end

    assign out_valid = st[NBLK-1].valid;
    assign diff      = st[NBLK-1].d;
    assign borrow    = st[NBLK-1].borrow;
    assign zero      = zero_q;

    // Group terms serve the adder-style hierarchy; this pipe chains bout.
    assign unused_bits = ^{blk_gg, blk_gp, st[NBLK-1].a, st[NBLK-1].b};

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed bench for pipelined_subtractor: reset, a vector table of single
// operations, a backpressure stream and a reset that lands mid-flight.
module tb_pipelined_subtractor;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_diff;
        logic        exp_borrow;
        logic        exp_zero;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    pipelined_subtractor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Issue one op, count edges (accept edge = 1) until out_valid, then
    // check the result and that it is emitted only once.
    task automatic runSingle(input vec_t v, input string tag);
        int edges;
        applyStimulus(1'b1, v.a, v.b);
        out_ready = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        edges = 1;
        while (!out_valid && edges < 12) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, "_latency"}, edges, NBLK);
        checkOutput({tag, "_diff"}, {16'h0, diff}, {16'h0, v.exp_diff});
        checkOutput({tag, "_borrow"}, {31'h0, borrow}, {31'h0, v.exp_borrow});
        checkOutput({tag, "_zero"}, {31'h0, zero}, {31'h0, v.exp_zero});
        @(posedge clk); #1;
        checkOutput({tag, "_nodup"}, {31'h0, out_valid}, 32'h0);
    endtask

    vec_t        vecs [8];
    logic [15:0] exp_bp [6];
    int          issued;
    int          got;
    logic        stalled_prev;
    logic [15:0] held_diff;
    logic        seen;

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0};
        vecs[3] = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h00F0, 16'h000F, 16'h00E1, 1'b0, 1'b0};
        vecs[7] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
        exp_bp[0] = 16'h1010;
        exp_bp[1] = 16'h2121;
        exp_bp[2] = 16'h3232;
        exp_bp[3] = 16'h4343;
        exp_bp[4] = 16'h5454;
        exp_bp[5] = 16'h6565;

        // Reset held two edges while operands are offered.
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h1111, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        #1;
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("rst_diff", {16'h0, diff}, 32'h0);
        checkOutput("rst_borrow", {31'h0, borrow}, 32'h0);
        checkOutput("rst_zero", {31'h0, zero}, 32'h0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checkOutput("rst_no_emit", {31'h0, seen}, 32'h0);

        for (int i = 0; i < 8; i++) runSingle(vecs[i], $sformatf("vec%0d", i));

        // Six back-to-back ops, consumer stalls in cycles 5..8.
        issued       = 0;
        got          = 0;
        stalled_prev = 1'b0;
        held_diff    = 16'h0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (issued < 6) applyStimulus(1'b1, 16'((issued + 1) * 16'h1111), 16'h0101);
            else            applyStimulus(1'b0, 16'h0000, 16'h0000);
            out_ready = !(cyc >= 5 && cyc <= 8);
            #1;
            if (stalled_prev) begin
                checkOutput("bp_hold_valid", {31'h0, out_valid}, 32'h1);
                checkOutput("bp_hold_diff", {16'h0, diff}, {16'h0, held_diff});
            end
            if (out_valid && !out_ready) begin
                checkOutput("bp_in_ready", {31'h0, in_ready}, 32'h0);
                held_diff    = diff;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (got < 6) begin
                    checkOutput($sformatf("bp_diff%0d", got), {16'h0, diff}, {16'h0, exp_bp[got]});
                    checkOutput($sformatf("bp_borrow%0d", got), {31'h0, borrow}, 32'h0);
                    checkOutput($sformatf("bp_zero%0d", got), {31'h0, zero}, 32'h0);
                end
                got++;
            end
            if (in_valid && in_ready) issued++;
            @(posedge clk); #1;
        end
        checkOutput("bp_count", got, 6);

        // Three ops in flight; reset arrives with the third.
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h1111, 16'h0001);
        @(posedge clk); #1;
        applyStimulus(1'b1, 16'h2222, 16'h0002);
        @(posedge clk); #1;
        applyStimulus(1'b1, 16'h3333, 16'h0003);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        checkOutput("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checkOutput("mid_rst_discard", {31'h0, seen}, 32'h0);
        runSingle('{16'h0F0F, 16'h0101, 16'h0E0E, 1'b0, 1'b0}, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
